// File: rtl/led_pattern_seq.sv
// led_pattern_seq: tick-driven LED bank sequencer with flow-left, flow-right, ping-pong and blink-all patterns
module led_pattern_seq #(
  parameter int LED_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tick,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led_out,
  output logic             cycle_done
);
  localparam logic INIT = 1'b0;
  localparam logic RUN  = 1'b1;
  localparam logic [1:0] M_LEFT  = 2'd0;
  localparam logic [1:0] M_RIGHT = 2'd1;
  localparam logic [1:0] M_PONG  = 2'd2;
  localparam logic [LED_W-1:0] ONE_LSB = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] ONE_MSB = {1'b1, {(LED_W-1){1'b0}}};
  logic             state;
  logic [1:0]       mode_q;
  logic             dir;
  logic [LED_W-1:0] start_pat;
  logic [LED_W-1:0] step_pat;
  logic             step_dir;
  logic             step_done;
  logic [LED_W-1:0] shl;
  logic [LED_W-1:0] shr;
  // start pattern for the requested mode: bit 0 for left/ping-pong, MSB for right, dark for blink
  always_comb begin
    start_pat = mode == M_RIGHT ? ONE_MSB : mode == M_LEFT || mode == M_PONG ? ONE_LSB : '0;
  end
  // one advance step of the active pattern, with its direction and period-complete flag
  always_comb begin
    shl       = led_out << 1;
    shr       = led_out >> 1;
    step_pat  = ~led_out;
    step_dir  = dir;
    step_done = &led_out;
    if (mode_q == M_LEFT) begin
      step_pat  = {led_out[LED_W-2:0], led_out[LED_W-1]};
      step_done = led_out == ONE_MSB;
    end else if (mode_q == M_RIGHT) begin
      step_pat  = {led_out[0], led_out[LED_W-1:1]};
      step_done = led_out == ONE_LSB;
    end else if (mode_q == M_PONG) begin
      step_pat  = dir ? shr : shl;
      step_dir  = dir ? ~shr[0] : shl[LED_W-1];
      step_done = dir & shr[0];
    end
  end
  // sequencer state: a mode change outranks a tick, a held enable freezes position and direction
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= INIT;
      mode_q     <= '0;
      dir        <= 1'b0;
      led_out    <= '0;
      cycle_done <= 1'b0;
    end else if (state == INIT || mode != mode_q) begin
      state      <= RUN;
      mode_q     <= mode;
      dir        <= 1'b0;
      led_out    <= start_pat;
      cycle_done <= 1'b0;
    end else if (tick && enable) begin
      dir        <= step_dir;
      led_out    <= step_pat;
      cycle_done <= step_done;
    end else begin
      cycle_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed checks of every pattern, mode switch, enable hold and async reset
module tb_led_pattern_seq;
  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       tick = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [3:0] led_out;
  logic       cycle_done;
  int errors = 0;
  int checks = 0;

  led_pattern_seq #(.LED_W(4)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .tick(tick),
    .enable(enable),
    .mode(mode),
    .led_out(led_out),
    .cycle_done(cycle_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input logic t);
    tick = t;
    @(posedge sys_clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    mode = 2'd0;
    enable = 1'b1;
    step(1'b0);
    step(1'b0);
    checks++;
    if (led_out !== 4'b0000 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: led_out=%b cycle_done=%b, wanted 0000/0", led_out, cycle_done);
    end
    sys_rst = 1'b1;
    step(1'b0);
    checks++;
    if (led_out !== 4'b0001 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: led_out=%b cycle_done=%b, wanted 0001/0", led_out, cycle_done);
    end
  endtask

  task automatic test_flow_left();
    logic [15:0] seq = 16'h1842;
    logic [3:0]  cd = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      checks++;
      if (led_out !== seq[4*i +: 4] || cycle_done !== cd[i]) begin
        errors++;
        $display("FAIL flow_left[%0d]: led_out=%b cycle_done=%b, wanted %b/%b", i, led_out, cycle_done, seq[4*i +: 4], cd[i]);
      end
    end
    step(1'b0);
    checks++;
    if (led_out !== 4'b0001 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL flow_left_idle: led_out=%b cycle_done=%b, wanted 0001/0", led_out, cycle_done);
    end
  endtask

  task automatic test_ping_pong();
    logic [27:0] seq = 28'h2124842;
    logic [6:0]  cd = 7'b0100000;
    mode = 2'd2;
    step(1'b0);
    checks++;
    if (led_out !== 4'b0001 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL pong_start: led_out=%b cycle_done=%b, wanted 0001/0", led_out, cycle_done);
    end
    for (int i = 0; i < 7; i++) begin
      step(1'b1);
      checks++;
      if (led_out !== seq[4*i +: 4] || cycle_done !== cd[i]) begin
        errors++;
        $display("FAIL pong[%0d]: led_out=%b cycle_done=%b, wanted %b/%b", i, led_out, cycle_done, seq[4*i +: 4], cd[i]);
      end
    end
  endtask

  task automatic test_blink();
    logic [11:0] seq = 12'hF0F;
    logic [2:0]  cd = 3'b010;
    mode = 2'd3;
    step(1'b0);
    checks++;
    if (led_out !== 4'b0000 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL blink_start: led_out=%b cycle_done=%b, wanted 0000/0", led_out, cycle_done);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      checks++;
      if (led_out !== seq[4*i +: 4] || cycle_done !== cd[i]) begin
        errors++;
        $display("FAIL blink[%0d]: led_out=%b cycle_done=%b, wanted %b/%b", i, led_out, cycle_done, seq[4*i +: 4], cd[i]);
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      checks++;
      if (led_out !== 4'b1111 || cycle_done !== 1'b0) begin
        errors++;
        $display("FAIL blink_hold[%0d]: led_out=%b cycle_done=%b, wanted 1111/0", i, led_out, cycle_done);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_mode_switch();
    mode = 2'd0;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    checks++;
    if (led_out !== 4'b0100) begin
      errors++;
      $display("FAIL switch_setup: led_out=%b, wanted 0100", led_out);
    end
    mode = 2'd1;
    step(1'b1);
    checks++;
    if (led_out !== 4'b1000 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL switch_load: led_out=%b cycle_done=%b, wanted 1000/0", led_out, cycle_done);
    end
    step(1'b1);
    checks++;
    if (led_out !== 4'b0100 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL switch_step: led_out=%b cycle_done=%b, wanted 0100/0", led_out, cycle_done);
    end
  endtask

  task automatic test_enable_hold();
    mode = 2'd2;
    step(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);
    checks++;
    if (led_out !== 4'b0100) begin
      errors++;
      $display("FAIL hold_setup: led_out=%b, wanted 0100", led_out);
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1);
    checks++;
    if (led_out !== 4'b0100 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL hold_frozen: led_out=%b cycle_done=%b, wanted 0100/0", led_out, cycle_done);
    end
    enable = 1'b1;
    step(1'b1);
    checks++;
    if (led_out !== 4'b0010) begin
      errors++;
      $display("FAIL hold_resume: led_out=%b, wanted 0010", led_out);
    end
    step(1'b1);
    checks++;
    if (led_out !== 4'b0001 || cycle_done !== 1'b1) begin
      errors++;
      $display("FAIL hold_period: led_out=%b cycle_done=%b, wanted 0001/1", led_out, cycle_done);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'd0;
    step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    checks++;
    if (led_out !== 4'b1000) begin
      errors++;
      $display("FAIL areset_setup: led_out=%b, wanted 1000", led_out);
    end
    #2;
    sys_rst = 1'b0;
    #1;
    checks++;
    if (led_out !== 4'b0000 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: led_out=%b cycle_done=%b, wanted 0000/0", led_out, cycle_done);
    end
    mode = 2'd1;
    step(1'b0);
    sys_rst = 1'b1;
    step(1'b1);
    checks++;
    if (led_out !== 4'b1000 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL areset_restart: led_out=%b cycle_done=%b, wanted 1000/0", led_out, cycle_done);
    end
    step(1'b1);
    checks++;
    if (led_out !== 4'b0100) begin
      errors++;
      $display("FAIL areset_step: led_out=%b, wanted 0100", led_out);
    end
  endtask

  initial begin
    test_reset();
    test_flow_left();
    test_ping_pong();
    test_blink();
    test_mode_switch();
    test_enable_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
